u_instr_encoder: RTL and testbench
==================================

# u_instr_encoder

Encoder and writer for U/J-type instructions (LUI, AUIPC, JAL), the inverse of the `control_gen` opcode decode. It accepts instruction requests over a valid/ready handshake and packs each one into a 32-bit RV32I instruction word. Encoded words go into a small FIFO and are written sequentially into instruction memory through a write port with backpressure. The block sits in the loader/self-test path that fills IMEM before the single-cycle core runs.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 10, IMEM word-address width
- BASE_ADDR, 0, first IMEM word address after reset/clear

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush: empties FIFO, address ← BASE_ADDR, err ← 0
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_kind  in  2  01 LUI, 10 AUIPC, 11 JAL, 00 invalid
- req_rd  in  5  destination register
- req_imm  in  32  LUI/AUIPC: imm[31:12] used; JAL: signed byte offset, imm[20:1] used
- mem_we  out  1  write request to IMEM
- mem_ready  in  1  IMEM accepts the write this cycle
- mem_addr  out  ADDR_W  word address of the current write
- mem_wdata  out  32  encoded instruction
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- err  out  1  sticky: an invalid kind or a misaligned JAL was seen

## Operation
- Request accept: req_valid & req_ready on a rising edge.
- Encoding happens at accept; the FIFO stores encoded words:
  - LUI: {imm[31:12], rd, 7'b0110111}
  - AUIPC: {imm[31:12], rd, 7'b0010111}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}
- Unused immediate bits are ignored.
- JAL with imm[0]=1: the word is still encoded and enqueued, and err is set.
- kind 00: the handshake completes but nothing is enqueued; err is set.
- req_ready = (level < DEPTH) & ~clear. It does not depend on mem_ready.
- mem_we = (level != 0) & ~clear. mem_wdata is the FIFO head.
- Pop on mem_we & mem_ready. On each pop, mem_addr increments by 1 and wraps from 2^ADDR_W−1 to 0.
- Simultaneous push and pop: level unchanged, both take effect. A push into a full FIFO cannot occur because req_ready is 0.
- clear has priority over push and pop in the same cycle; the request offered that cycle is not accepted.
- err clears only on clear or reset. If clear and an erroneous request coincide, the request is not accepted, so err ends at 0.
- Words are written strictly in accept order.

## Timing
- Reset values (async, on rst_n low, immediately): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, level=0, err=0, FIFO pointers 0.
  - req_ready=1 whenever rst_n is low or FIFO is empty with clear=0.
- Reset mid-operation discards all queued words. No partial write is issued after rst_n falls.
- Latency: a request accepted at edge N appears with mem_we=1 in the cycle after edge N. With mem_ready held high, it is written at edge N+1.
- Throughput: one accept and one write per cycle sustained, with mem_ready high.
- mem_we, mem_addr, and mem_wdata are held stable while mem_we=1 and mem_ready=0.
- All outputs are registered or decoded from registers only. req_ready and mem_we also see clear combinationally.

## Test plan
- LUI rd=5, imm=0x12345000, mem_ready=1 → next cycle mem_we=1, mem_addr=0, mem_wdata=0x123452B7; err=0.
- Back-to-back AUIPC rd=1 imm=0xFFFFF000, JAL rd=1 imm=8, JAL rd=0 imm=0xFFFFFFFC → writes 0xFFFFF097 @0, 0x008000EF @1, 0xFFDFF06F @2 on consecutive cycles.
- Backpressure: mem_ready=0, offer 5 requests → 4 accepted, level=4, req_ready=0. Raise mem_ready → 4 writes at addresses 0..3 in order, then the 5th is accepted.
- Wrap with ADDR_W=2: six LUIs → addresses 0,1,2,3,0,1.
- Errors: kind=00 → accepted, no write, err=1. JAL imm=0x5 → word enqueued, err stays 1. clear pulse → err=0, level=0, next write at BASE_ADDR.
- Reset mid-op: 3 words queued, mem_ready=0, drop rst_n → mem_we=0 and level=0 immediately. After release, req_ready=1 and mem_addr=BASE_ADDR.

Source files
------------

// File: rtl/u_instr_encoder.sv
// U/J-type instruction encoder (LUI, AUIPC, JAL) feeding a small FIFO that
// drains into instruction memory through a write port with backpressure.
module u_instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_kind,
    input  logic [4:0]                   req_rd,
    input  logic [31:0]                  req_imm,
    output logic                         mem_we,
    input  logic                         mem_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0]     FULL_LEVEL = LW'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_LUI   = 2'b01;
    localparam logic [1:0] KIND_AUIPC = 2'b10;
    localparam logic [1:0] KIND_JAL   = 2'b11;

    logic [31:0]       fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic        bad_req;
    logic [31:0] enc_word;

    // Words are encoded at accept time so the FIFO only ever holds final words.
    always_comb begin
        enc_word = '0;
        case (req_kind)
            KIND_LUI:   enc_word = {req_imm[31:12], req_rd, 7'b0110111};
            KIND_AUIPC: enc_word = {req_imm[31:12], req_rd, 7'b0010111};
            KIND_JAL:   enc_word = {req_imm[20], req_imm[10:1], req_imm[11],
                                    req_imm[19:12], req_rd, 7'b1101111};
            default:    enc_word = '0;
        endcase
    end

    assign req_ready = (level_q < FULL_LEVEL) & ~clear;
    assign mem_we    = (level_q != '0) & ~clear;
    assign mem_addr  = addr_q;
    assign mem_wdata = (level_q != '0) ? fifo_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign err       = err_q;

    assign accept  = req_valid & req_ready;
    assign push    = accept & (req_kind != KIND_NONE);
    assign pop     = mem_we & mem_ready;
    assign bad_req = (req_kind == KIND_NONE) | ((req_kind == KIND_JAL) & req_imm[0]);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        addr_d   = addr_q;
        err_d    = err_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            addr_d   = BASE;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (accept & bad_req) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            addr_q   <= BASE;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: the head is only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_u_instr_encoder.sv
// Randomized and directed bench for u_instr_encoder, checked every cycle
// against a queue-based reference model of the encoder and IMEM writer.
module tb_u_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int BASE   = 0;
    localparam int NADDR  = 1 << ADDR_W;

    logic              clk;
    logic              rstN;
    logic              clear;
    logic              reqValid;
    logic              reqReady;
    logic [1:0]        reqKind;
    logic [4:0]        reqRd;
    logic [31:0]       reqImm;
    logic              memWe;
    logic              memReady;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [2:0]        level;
    logic              err;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [31:0] expQ [$];
    int          mAddr;
    bit          mErr;

    // Last values sampled from the DUT
    logic        sWe, sReady, sErr;
    logic [31:0] sWdata;
    logic [31:0] sAddr;
    logic [31:0] sLevel;

    u_instr_encoder #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rstN),
        .clear(clear),
        .req_valid(reqValid),
        .req_ready(reqReady),
        .req_kind(reqKind),
        .req_rd(reqRd),
        .req_imm(reqImm),
        .mem_we(memWe),
        .mem_ready(memReady),
        .mem_addr(memAddr),
        .mem_wdata(memWdata),
        .level(level),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checkCount++;
        if (obs !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, expected, $time);
        end
    endtask

    // Field-by-field assembly of the instruction word using shifts and masks
    function automatic logic [31:0] modelEncode(input int kind, input int rd, input logic [31:0] imm);
        longint unsigned w;
        case (kind)
            1: w = (longint'(imm) & 64'hFFFFF000) + (rd << 7) + 55;
            2: w = (longint'(imm) & 64'hFFFFF000) + (rd << 7) + 23;
            3: w = (((imm >> 20) & 1) << 31) + (((imm >> 1) & 32'h3FF) << 21)
                 + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 32'hFF) << 12)
                 + (rd << 7) + 111;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic modelReset();
        expQ.delete();
        mAddr = BASE;
        mErr  = 1'b0;
    endtask

    // Sample at the falling edge, compare with the model, advance the model,
    // then let the rising edge happen and return just after it.
    task automatic stepCycle();
        bit mReady, mWe, accept;
        @(negedge clk);
        sWe    = memWe;
        sReady = reqReady;
        sErr   = err;
        sWdata = memWdata;
        sAddr  = 32'(memAddr);
        sLevel = 32'(level);
        mReady = !clear && (expQ.size() < DEPTH);
        mWe    = !clear && (expQ.size() != 0);
        checkOutput("req_ready", 32'(sReady), 32'(mReady));
        checkOutput("mem_we", 32'(sWe), 32'(mWe));
        checkOutput("level", sLevel, expQ.size());
        checkOutput("err", 32'(sErr), 32'(mErr));
        if (mWe) begin
            checkOutput("mem_addr", sAddr, mAddr);
            checkOutput("mem_wdata", sWdata, expQ[0]);
        end
        accept = reqValid && mReady;
        if (clear) begin
            modelReset();
        end else begin
            if (mWe && memReady) begin
                void'(expQ.pop_front());
                mAddr = (mAddr + 1) % NADDR;
            end
            if (accept) begin
                if (reqKind == 2'b00) mErr = 1'b1;
                else expQ.push_back(modelEncode(reqKind, reqRd, reqImm));
                if (reqKind == 2'b11 && reqImm[0]) mErr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input logic [1:0] kind, input logic [4:0] rd,
                                 input logic [31:0] imm, input bit mReady, input bit clr);
        reqValid = valid;
        reqKind  = kind;
        reqRd    = rd;
        reqImm   = imm;
        memReady = mReady;
        clear    = clr;
        stepCycle();
    endtask

    task automatic idle(input bit mReady);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, mReady, 1'b0);
    endtask

    initial begin
        modelReset();
        rstN = 1'b0;
        clear = 1'b0; reqValid = 1'b0; reqKind = 2'b00; reqRd = '0; reqImm = '0; memReady = 1'b0;
        #2;
        checkOutput("rst_we", 32'(memWe), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_addr", 32'(memAddr), BASE);
        checkOutput("rst_wdata", memWdata, 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_ready", 32'(reqReady), 1);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Single LUI
        applyStimulus(1'b1, 2'b01, 5'd5, 32'h12345000, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("lui_we", 32'(sWe), 1);
        checkOutput("lui_addr", sAddr, 0);
        checkOutput("lui_word", sWdata, 32'h123452B7);

        // Back-to-back AUIPC / JAL / JAL from a fresh address
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b10, 5'd1, 32'hFFFFF000, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 5'd1, 32'h00000008, 1'b1, 1'b0);
        checkOutput("auipc_word", sWdata, 32'hFFFFF097);
        checkOutput("auipc_addr", sAddr, 0);
        applyStimulus(1'b1, 2'b11, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0);
        checkOutput("jal8_word", sWdata, 32'h008000EF);
        checkOutput("jal8_addr", sAddr, 1);
        idle(1'b1);
        checkOutput("jalneg_word", sWdata, 32'hFFDFF06F);
        checkOutput("jalneg_addr", sAddr, 2);
        idle(1'b1);

        // Backpressure: five offered, four fit, the fifth waits for a pop
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 5'(i + 1), 32'(i) << 12, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 5'd5, 32'h4000, 1'b0, 1'b0);
        checkOutput("bp_level", sLevel, 4);
        checkOutput("bp_ready", 32'(sReady), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 5'd5, 32'h4000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        checkOutput("bp_drained", sLevel, 0);

        // Address wrap across the 2-bit address space
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b01, 5'(i), 32'h0ABCD000, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("wrap_addr", sAddr, 1);

        // Error handling
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b00, 5'd3, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("kind0_err", 32'(sErr), 1);
        checkOutput("kind0_level", sLevel, 0);
        applyStimulus(1'b1, 2'b11, 5'd2, 32'h00000005, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("misalign_level", sLevel, 1);
        applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b01, 5'd7, 32'h77777000, 1'b1, 1'b0);
        checkOutput("clear_err", 32'(sErr), 0);
        checkOutput("clear_level", sLevel, 0);
        idle(1'b1);
        checkOutput("clear_addr", sAddr, BASE);

        // Asynchronous reset with queued words
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 5'(i), 32'hABC00000, 1'b0, 1'b0);
        reqValid = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst_we", 32'(memWe), 0);
        checkOutput("arst_level", 32'(level), 0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        idle(1'b1);
        checkOutput("arst_ready", 32'(sReady), 1);
        checkOutput("arst_addr", sAddr, BASE);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] k;
            k = ($urandom_range(0, 11) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            applyStimulus(1'($urandom_range(0, 3) != 0), k, 5'($urandom), 32'($urandom),
                          1'($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
